// File: rtl/decode_cycle_if.sv
// ID-stage boundary bundle: fetch, writeback and hazard inputs plus the ID/EX register outputs.
interface decode_cycle_if #(parameter int XLEN = 32);
   logic [31:0]     InstrD;
   logic [XLEN-1:0] PCD;
   logic [XLEN-1:0] PCPlus4D;
   logic            RegWriteW;
   logic [4:0]      RdW;
   logic [XLEN-1:0] ResultW;
   logic            FlushE;

   logic            RegWriteE;
   logic [1:0]      ResultSrcE;
   logic            MemWriteE;
   logic            JumpE;
   logic            JalrE;
   logic            BranchE;
   logic            ALUSrcAE;
   logic            ALUSrcE;
   logic [3:0]      ALUControlE;
   logic [2:0]      Funct3E;
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] ImmExtE;
   logic [4:0]      Rs1E;
   logic [4:0]      Rs2E;
   logic [4:0]      RdE;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCPlus4E;

   modport master (
      output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
      input  RegWriteE, ResultSrcE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcAE, ALUSrcE,
             ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
   );

   modport slave (
      input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
      output RegWriteE, ResultSrcE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcAE, ALUSrcE,
             ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
   );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: main/ALU decoder, immediate extender, 32-entry register file
// with WB->ID write-through, and the ID/EX pipeline register.
module decode_cycle #(
   parameter int NREG = 32,
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          reset,
   decode_cycle_if.slave bus
);
   localparam int AW = 5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
      ALU_XOR  = 4'b0100, ALU_SLT  = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111,
      ALU_SRL  = 4'b1000, ALU_SRA  = 4'b1001, ALU_PASSB = 4'b1010
   } alu_e;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       jalr;
      logic       branch;
      logic       alu_src_a;
      logic       alu_src;
      alu_e       alu_ctl;
   } ctl_t;

   typedef struct packed {
      ctl_t            ctl;
      logic [2:0]      funct3;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
   } idex_t;

   logic [31:0]   instr;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          f7b5;
   logic [AW-1:0] rs1, rs2, rd;

   assign instr  = bus.InstrD;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign f7b5   = instr[30];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign rd     = instr[11:7];

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

   assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};

   alu_e alu_arith, alu_branch;

   // funct7[5] only means sub for register-register ops; for immediates it is imm data
   always_comb begin
      alu_arith = ALU_ADD;
      case (funct3)
         3'b000:  alu_arith = (f7b5 && opcode == OP_R) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_arith = ALU_SLL;
         3'b010:  alu_arith = ALU_SLT;
         3'b011:  alu_arith = ALU_SLTU;
         3'b100:  alu_arith = ALU_XOR;
         3'b101:  alu_arith = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_arith = ALU_OR;
         default: alu_arith = ALU_AND;
      endcase
   end

   always_comb begin
      case (funct3[2:1])
         2'b10:   alu_branch = ALU_SLT;
         2'b11:   alu_branch = ALU_SLTU;
         default: alu_branch = ALU_SUB;
      endcase
   end

   ctl_t            ctl;
   logic [XLEN-1:0] imm;

   always_comb begin
      ctl = '0;
      imm = '0;
      case (opcode)
         OP_R: begin
            ctl.reg_write = 1'b1;
            ctl.alu_ctl   = alu_arith;
         end
         OP_I: begin
            ctl.reg_write = 1'b1;
            ctl.alu_src   = 1'b1;
            ctl.alu_ctl   = alu_arith;
            imm           = imm_i;
         end
         OP_LOAD: begin
            ctl.reg_write  = 1'b1;
            ctl.result_src = 2'b01;
            ctl.alu_src    = 1'b1;
            imm            = imm_i;
         end
         OP_STORE: begin
            ctl.mem_write = 1'b1;
            ctl.alu_src   = 1'b1;
            imm           = imm_s;
         end
         OP_BRANCH: begin
            ctl.branch  = 1'b1;
            ctl.alu_ctl = alu_branch;
            imm         = imm_b;
         end
         OP_JAL: begin
            ctl.reg_write  = 1'b1;
            ctl.result_src = 2'b10;
            ctl.jump       = 1'b1;
            imm            = imm_j;
         end
         OP_JALR: begin
            ctl.reg_write  = 1'b1;
            ctl.result_src = 2'b10;
            ctl.jalr       = 1'b1;
            ctl.alu_src    = 1'b1;
            imm            = imm_i;
         end
         OP_LUI: begin
            ctl.reg_write = 1'b1;
            ctl.alu_src   = 1'b1;
            ctl.alu_ctl   = ALU_PASSB;
            imm           = imm_u;
         end
         OP_AUIPC: begin
            ctl.reg_write = 1'b1;
            ctl.alu_src_a = 1'b1;
            ctl.alu_src   = 1'b1;
            imm           = imm_u;
         end
         default: ;
      endcase
   end

   logic [NREG-1:0][XLEN-1:0] rf;
   logic                      wr_en;
   logic [XLEN-1:0]           rd1, rd2;

   assign wr_en = bus.RegWriteW && (bus.RdW != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      rf <= '0;
      else if (wr_en) rf[bus.RdW] <= bus.ResultW;
   end

   // Write-through lets an instruction in ID see the value WB is retiring this cycle
   assign rd1 = (rs1 == '0) ? '0 : (wr_en && bus.RdW == rs1) ? bus.ResultW : rf[rs1];
   assign rd2 = (rs2 == '0) ? '0 : (wr_en && bus.RdW == rs2) ? bus.ResultW : rf[rs2];

   idex_t idex_d, idex_q;

   assign idex_d = '{ctl: ctl, funct3: funct3, rd1: rd1, rd2: rd2, imm: imm,
                     rs1: rs1, rs2: rs2, rd: rd, pc: bus.PCD, pc4: bus.PCPlus4D};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           idex_q <= '0;
      else if (bus.FlushE) idex_q <= '0;
      else                 idex_q <= idex_d;
   end

   assign bus.RegWriteE   = idex_q.ctl.reg_write;
   assign bus.ResultSrcE  = idex_q.ctl.result_src;
   assign bus.MemWriteE   = idex_q.ctl.mem_write;
   assign bus.JumpE       = idex_q.ctl.jump;
   assign bus.JalrE       = idex_q.ctl.jalr;
   assign bus.BranchE     = idex_q.ctl.branch;
   assign bus.ALUSrcAE    = idex_q.ctl.alu_src_a;
   assign bus.ALUSrcE     = idex_q.ctl.alu_src;
   assign bus.ALUControlE = idex_q.ctl.alu_ctl;
   assign bus.Funct3E     = idex_q.funct3;
   assign bus.RD1E        = idex_q.rd1;
   assign bus.RD2E        = idex_q.rd2;
   assign bus.ImmExtE     = idex_q.imm;
   assign bus.Rs1E        = idex_q.rs1;
   assign bus.Rs2E        = idex_q.rs2;
   assign bus.RdE         = idex_q.rd;
   assign bus.PCE         = idex_q.pc;
   assign bus.PCPlus4E    = idex_q.pc4;
endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: vector table of instructions with hand-derived controls and
// immediates, a shadow register file for operands, and a scoreboard queue of expected ID/EX words.
module tb_decode_cycle;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   decode_cycle_if #(.XLEN(32)) bus ();
   decode_cycle #(.NREG(32), .XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct packed {
      logic rw; logic [1:0] rs; logic mw, jmp, jalr, br, sa, sb; logic [3:0] alu;
      logic [2:0] f3; logic [31:0] rd1, rd2, imm; logic [4:0] rs1, rs2, rd; logic [31:0] pc, pc4;
   } out_t;

   typedef struct packed { out_t exp; out_t mask; } sb_t;

   typedef struct {
      logic [31:0] instr, pc; logic flush, wen; logic [4:0] wrd; logic [31:0] wdata;
      logic [12:0] ctl; logic [31:0] imm; logic care;
   } vec_t;

   vec_t        vt[$];
   sb_t         sbq[$];
   logic [31:0] mrf[32];
   int          n_vec = 0;
   int          n_bad = 0;

   localparam logic [6:0] OPI = 7'b0010011;

   function automatic logic [12:0] C(input logic rw, input logic [1:0] rs, input logic mw,
      input logic j, input logic jr, input logic b, input logic sa, input logic sb, input logic [3:0] alu);
      return {rw, rs, mw, j, jr, b, sa, sb, alu};
   endfunction

   function automatic logic [31:0] r_i(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] i_t(input logic [11:0] im, input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd, input logic [6:0] op);
      return {im, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] s_t(input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3);
      return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] b_t(input logic [12:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3);
      return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] u_t(input logic [19:0] im, input logic [4:0] rd, input logic [6:0] op);
      return {im, rd, op};
   endfunction
   function automatic logic [31:0] j_t(input logic [20:0] im, input logic [4:0] rd);
      return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
   endfunction

   task automatic add(input logic [31:0] instr, input logic [31:0] pc, input logic fl, input logic we,
      input logic [4:0] wrd, input logic [31:0] wd, input logic [12:0] ctl, input logic [31:0] imm,
      input logic care);
      vec_t v;
      v.instr = instr; v.pc = pc; v.flush = fl; v.wen = we; v.wrd = wrd; v.wdata = wd;
      v.ctl = ctl; v.imm = imm; v.care = care;
      vt.push_back(v);
   endtask

   task automatic addv(input logic [31:0] instr, input logic [12:0] ctl, input logic [31:0] imm,
      input logic care);
      add(instr, 32'h100 + 32'(vt.size() * 4), 1'b0, 1'b0, 5'd0, 32'd0, ctl, imm, care);
   endtask

   function automatic logic [31:0] rdp(input logic [4:0] a, input vec_t v);
      if (a == 5'd0) return 32'd0;
      if (v.wen && v.wrd == a) return v.wdata;
      return mrf[a];
   endfunction

   function automatic out_t model(input vec_t v);
      out_t o;
      o = '0;
      if (v.flush) return o;
      {o.rw, o.rs, o.mw, o.jmp, o.jalr, o.br, o.sa, o.sb, o.alu} = v.ctl;
      o.f3  = v.instr[14:12];
      o.rs1 = v.instr[19:15];
      o.rs2 = v.instr[24:20];
      o.rd  = v.instr[11:7];
      o.rd1 = rdp(o.rs1, v);
      o.rd2 = rdp(o.rs2, v);
      o.imm = v.imm;
      o.pc  = v.pc;
      o.pc4 = v.pc + 32'd4;
      return o;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.rw = bus.RegWriteE; o.rs = bus.ResultSrcE; o.mw = bus.MemWriteE; o.jmp = bus.JumpE;
      o.jalr = bus.JalrE; o.br = bus.BranchE; o.sa = bus.ALUSrcAE; o.sb = bus.ALUSrcE;
      o.alu = bus.ALUControlE; o.f3 = bus.Funct3E; o.rd1 = bus.RD1E; o.rd2 = bus.RD2E;
      o.imm = bus.ImmExtE; o.rs1 = bus.Rs1E; o.rs2 = bus.Rs2E; o.rd = bus.RdE;
      o.pc = bus.PCE; o.pc4 = bus.PCPlus4E;
      return o;
   endfunction

   task automatic check(input string nm);
      out_t act;
      sb_t  e;
      act = sample();
      n_vec++;
      if (sbq.size() == 0) begin
         n_bad++;
         $display("FAIL %s: output produced with no expected entry queued", nm);
         return;
      end
      e = sbq.pop_front();
      if (((act ^ e.exp) & e.mask) !== '0) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, e.exp);
      end
   endtask

   task automatic check_zero(input string nm);
      out_t act;
      act = sample();
      n_vec++;
      if (act !== '0) begin
         n_bad++;
         $display("FAIL %s: got %h want all-zero", nm, act);
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      sb_t e;
      @(negedge clk);
      bus.InstrD = v.instr; bus.PCD = v.pc; bus.PCPlus4D = v.pc + 32'd4;
      bus.FlushE = v.flush; bus.RegWriteW = v.wen; bus.RdW = v.wrd; bus.ResultW = v.wdata;
      e.exp  = model(v);
      e.mask = '1;
      if (!v.care) e.mask.imm = '0;
      sbq.push_back(e);
      @(posedge clk);
      if (v.wen && v.wrd != 5'd0) mrf[v.wrd] = v.wdata;
      #1 check(nm);
   endtask

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: run exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [12:0] RADD, IC, JC;
      vec_t        v;
      reset = 1'b1;
      bus.InstrD = '0; bus.PCD = '0; bus.PCPlus4D = '0; bus.FlushE = 1'b0;
      bus.RegWriteW = 1'b0; bus.RdW = '0; bus.ResultW = '0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      #12 check_zero("reset_state");
      @(negedge clk) reset = 1'b0;

      RADD = C(1, 2'b00, 0, 0, 0, 0, 0, 0, 4'h0);
      IC   = C(1, 2'b00, 0, 0, 0, 0, 0, 1, 4'h0);
      JC   = C(1, 2'b10, 0, 1, 0, 0, 0, 0, 4'h0);
      add(32'h006283B3, 32'h100, 0, 1, 5'd5, 32'h1234, RADD, 0, 0);
      add(r_i(7'h20, 6, 5, 3'b000, 8), 32'h104, 0, 1, 5'd6, 32'hABCD0000, RADD | 13'h1, 0, 0);
      add(r_i(7'h00, 0, 0, 3'b000, 9), 32'h108, 0, 1, 5'd0, 32'hFFFFFFFF, RADD, 0, 0);
      addv(r_i(7'h00, 5, 0, 3'b110, 10), RADD | 13'h3, 0, 0);
      addv(r_i(7'h20, 5, 6, 3'b101, 11), RADD | 13'h9, 0, 0);
      addv(r_i(7'h00, 5, 6, 3'b101, 11), RADD | 13'h8, 0, 0);
      addv(r_i(7'h00, 5, 6, 3'b001, 12), RADD | 13'h7, 0, 0);
      addv(r_i(7'h00, 5, 6, 3'b010, 12), RADD | 13'h5, 0, 0);
      addv(r_i(7'h00, 5, 6, 3'b011, 12), RADD | 13'h6, 0, 0);
      addv(r_i(7'h00, 5, 6, 3'b100, 12), RADD | 13'h4, 0, 0);
      addv(r_i(7'h00, 5, 6, 3'b111, 12), RADD | 13'h2, 0, 0);
      addv(i_t(12'hFFF, 5, 3'b000, 12, OPI), IC,          32'hFFFFFFFF, 1);
      addv(i_t(12'h403, 6, 3'b101, 13, OPI), IC | 13'h9, 32'h00000403, 1);
      addv(i_t(12'h005, 6, 3'b101, 13, OPI), IC | 13'h8, 32'h00000005, 1);
      addv(i_t(12'h01F, 6, 3'b001, 13, OPI), IC | 13'h7, 32'h0000001F, 1);
      addv(i_t(12'h7FF, 5, 3'b010, 14, OPI), IC | 13'h5, 32'h000007FF, 1);
      addv(i_t(12'h800, 5, 3'b011, 14, OPI), IC | 13'h6, 32'hFFFFF800, 1);
      addv(i_t(12'h0AA, 5, 3'b100, 14, OPI), IC | 13'h4, 32'h000000AA, 1);
      addv(i_t(12'h555, 5, 3'b110, 14, OPI), IC | 13'h3, 32'h00000555, 1);
      addv(i_t(12'hF0F, 5, 3'b111, 14, OPI), IC | 13'h2, 32'hFFFFFF0F, 1);
      addv(32'hFFC12083, C(1, 2'b01, 0, 0, 0, 0, 0, 1, 4'h0), 32'hFFFFFFFC, 1);
      addv(s_t(12'h00C, 5, 6, 3'b010), C(0, 2'b00, 1, 0, 0, 0, 0, 1, 4'h0), 32'h0000000C, 1);
      addv(s_t(12'h800, 6, 5, 3'b000), C(0, 2'b00, 1, 0, 0, 0, 0, 1, 4'h0), 32'hFFFFF800, 1);
      addv(b_t(13'h1FF0, 6, 5, 3'b000), C(0, 2'b00, 0, 0, 0, 1, 0, 0, 4'h1), 32'hFFFFFFF0, 1);
      addv(b_t(13'h0800, 6, 5, 3'b100), C(0, 2'b00, 0, 0, 0, 1, 0, 0, 4'h5), 32'h00000800, 1);
      addv(b_t(13'h0FFE, 6, 5, 3'b111), C(0, 2'b00, 0, 0, 0, 1, 0, 0, 4'h6), 32'h00000FFE, 1);
      addv(b_t(13'h1002, 6, 5, 3'b001), C(0, 2'b00, 0, 0, 0, 1, 0, 0, 4'h1), 32'hFFFFF002, 1);
      add(32'h008000EF, 32'h10, 0, 0, 5'd0, 32'd0, JC, 32'h00000008, 1);
      addv(j_t(21'h100000, 0), JC, 32'hFFF00000, 1);
      addv(j_t(21'h0AAAAA, 5), JC, 32'h000AAAAA, 1);
      addv(i_t(12'h004, 5, 3'b000, 1, 7'b1100111), C(1, 2'b10, 0, 0, 1, 0, 0, 1, 4'h0), 32'h4, 1);
      addv(u_t(20'hDEADB, 14, 7'b0110111), C(1, 2'b00, 0, 0, 0, 0, 0, 1, 4'hA), 32'hDEADB000, 1);
      addv(u_t(20'h12345, 15, 7'b0010111), C(1, 2'b00, 0, 0, 0, 0, 1, 1, 4'h0), 32'h12345000, 1);
      addv(32'h00000000, 13'h0, 0, 0);
      addv(i_t(12'h000, 0, 3'b101, 9, 7'h7F), 13'h0, 0, 0);
      add(b_t(13'h0008, 6, 5, 3'b000), 32'h200, 1, 1, 5'd20, 32'h5A5A5A5A, 13'h0, 0, 1);
      addv(r_i(7'h00, 20, 20, 3'b000, 21), RADD, 0, 0);

      foreach (vt[i]) apply(vt[i], $sformatf("vec%0d", i));

      // Async reset mid-run: outputs clear without waiting for an edge, regfile wiped
      @(negedge clk) reset = 1'b1;
      bus.FlushE = 1'b1;
      #1 check_zero("reset_async");
      @(posedge clk);
      #1 check_zero("reset_hold");
      @(negedge clk) reset = 1'b0;
      bus.FlushE = 1'b0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;

      for (int i = 1; i < 32; i++) begin
         v = '{instr: r_i(7'h00, 5'(32 - i), 5'(i), 3'b000, 5'd0), pc: 32'h300, flush: 1'b0,
               wen: 1'b0, wrd: 5'd0, wdata: 32'd0, ctl: RADD, imm: 32'd0, care: 1'b0};
         apply(v, $sformatf("clr_x%0d", i));
      end
      for (int i = 1; i < 32; i++) begin
         v = '{instr: r_i(7'h00, 5'(i), 5'(i), 3'b000, 5'd0), pc: 32'h400, flush: 1'b0,
               wen: 1'b1, wrd: 5'(i), wdata: $urandom, ctl: RADD, imm: 32'd0, care: 1'b0};
         apply(v, $sformatf("wr_x%0d", i));
      end
      for (int i = 1; i < 32; i++) begin
         v = '{instr: r_i(7'h00, 5'(32 - i), 5'(i), 3'b000, 5'd0), pc: 32'h500, flush: 1'b0,
               wen: 1'b0, wrd: 5'd0, wdata: 32'd0, ctl: RADD, imm: 32'd0, care: 1'b0};
         apply(v, $sformatf("rd_x%0d", i));
      end

      if (sbq.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d expected entries left, want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
